// File: rtl/riscv_mon_pkg.sv
// Shared encodings and table-entry geometry for the RISC-V checkpoint monitor.
// MON_MASK_EN adds a per-entry compare mask to the table layout.
package riscv_mon_pkg;

  localparam logic [2:0] MON_IDLE    = 3'd0;
  localparam logic [2:0] MON_RUN     = 3'd1;
  localparam logic [2:0] MON_PASS    = 3'd2;
  localparam logic [2:0] MON_FAIL    = 3'd3;
  localparam logic [2:0] MON_TIMEOUT = 3'd4;

  localparam logic [1:0] FC_NONE       = 2'd0;
  localparam logic [1:0] FC_MISMATCH   = 2'd1;
  localparam logic [1:0] FC_SKIP       = 2'd2;
  localparam logic [1:0] FC_EARLY_HALT = 2'd3;

  localparam int CNT_W = 32;

  // Width of one stored table entry / one hex-file line.
  function automatic int entry_w(input int dwidth);
`ifdef MON_MASK_EN
    return CNT_W + 2 * dwidth;
`else
    return CNT_W + dwidth;
`endif
  endfunction

  // Width of one entry in the TABLE_INIT image, which always carries {cnt, ans, mask}.
  function automatic int init_w(input int dwidth);
    return CNT_W + 2 * dwidth;
  endfunction

endpackage

// File: rtl/riscv_checkpoint_rom.sv
// Checkpoint table ROM built from the TABLE_INIT image ({cnt, ans, mask} per entry).
// Under MON_MASK_EN each entry also holds a compare mask; otherwise mask_o is all ones.
module riscv_checkpoint_rom
   import riscv_mon_pkg::*;
#(
   parameter int NUM_TEST   = 40,
   parameter int DWIDTH     = 32,
   parameter int IDX_W      = 6,
   parameter     TABLE_FILE = "checkpoints.hex",
   parameter logic [NUM_TEST*(32+2*DWIDTH)-1:0] TABLE_INIT = '0
) (
   input  logic [IDX_W-1:0]  ptr_i,
   output logic [CNT_W-1:0]  cnt_o,
   output logic [DWIDTH-1:0] ans_o,
   output logic [DWIDTH-1:0] mask_o
);

   localparam int EW    = entry_w(DWIDTH);
   localparam int IW    = init_w(DWIDTH);
   localparam int DEPTH = 2 ** IDX_W;

   // Depth is padded to the full pointer range so the terminal ptr==NUM_TEST is a legal read.
   logic [EW-1:0] rom_mem [DEPTH];
   logic [EW-1:0] entry;

   generate
      for (genvar i = 0; i < DEPTH; i++) begin : g_ent
         if (i < NUM_TEST) begin : g_used
            assign rom_mem[i] = TABLE_INIT[i*IW+IW-1 -: EW];
         end else begin : g_pad
            assign rom_mem[i] = '0;
         end
      end
   endgenerate

   assign entry = rom_mem[ptr_i];
   assign cnt_o = entry[EW-1 -: CNT_W];
   assign ans_o = entry[EW-CNT_W-1 -: DWIDTH];
`ifdef MON_MASK_EN
   assign mask_o = entry[DWIDTH-1:0];
`else
   assign mask_o = '1;
`endif

endmodule

// File: rtl/riscv_checkpoint_monitor.sv
// Checks a core's OUTPUT_PORT at table-listed instruction counts and holds a sticky verdict.
// Optional MON_MASK_EN: per-checkpoint compare mask (see riscv_checkpoint_rom).
module riscv_checkpoint_monitor
  import riscv_mon_pkg::*;
#(
  parameter int NUM_TEST    = 40,
  parameter int DWIDTH      = 32,
  parameter int CYCLE_LIMIT = 1000000,
  parameter     TABLE_FILE  = "checkpoints.hex",
  parameter logic [NUM_TEST*(32+2*DWIDTH)-1:0] TABLE_INIT = '0,
  localparam int IDX_W      = $clog2(NUM_TEST + 1)
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              START,
  input  logic [31:0]       NUM_INST,
  input  logic [DWIDTH-1:0] OUTPUT_PORT,
  input  logic              HALT,
  output logic [2:0]        STATE,
  output logic              DONE,
  output logic [1:0]        FAIL_CODE,
  output logic [IDX_W-1:0]  FAIL_IDX,
  output logic [DWIDTH-1:0] FAIL_GOT,
  output logic [DWIDTH-1:0] FAIL_EXP,
  output logic [IDX_W-1:0]  PASS_CNT,
  output logic [31:0]       CYCLE
);

  localparam logic [IDX_W-1:0] NUM_IDX  = IDX_W'(NUM_TEST);
  localparam logic [31:0]      CYC_LAST = 32'(CYCLE_LIMIT - 1);

  logic [2:0]        state_q, state_d;
  logic              done_q, done_d;
  logic [1:0]        code_q, code_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DWIDTH-1:0] got_q, got_d;
  logic [DWIDTH-1:0] exp_q, exp_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [31:0]       cycle_q, cycle_d;

  logic [CNT_W-1:0]  cp_cnt;
  logic [DWIDTH-1:0] cp_ans;
  logic [DWIDTH-1:0] cp_mask;

  riscv_checkpoint_rom #(
    .NUM_TEST  (NUM_TEST),
    .DWIDTH    (DWIDTH),
    .IDX_W     (IDX_W),
    .TABLE_FILE(TABLE_FILE),
    .TABLE_INIT(TABLE_INIT)
  ) u_rom (
    .ptr_i (ptr_q),
    .cnt_o (cp_cnt),
    .ans_o (cp_ans),
    .mask_o(cp_mask)
  );

  logic             ptr_live, at_cp, past_cp, cp_match, hit_ok;
  logic [IDX_W-1:0] ptr_next;
  logic [1:0]       code_now;

  assign ptr_live = (ptr_q != NUM_IDX);
  assign at_cp    = ptr_live && (NUM_INST == cp_cnt);
  assign past_cp  = ptr_live && (NUM_INST > cp_cnt);
  assign cp_match = (((OUTPUT_PORT ^ cp_ans) & cp_mask) == '0);
  assign hit_ok   = at_cp && cp_match;
  assign ptr_next = ptr_q + IDX_W'(hit_ok);

  // Mismatch and skip outrank HALT; HALT only passes once every entry has matched.
  always_comb begin
    code_now = FC_NONE;
    if (at_cp && !cp_match)              code_now = FC_MISMATCH;
    else if (past_cp)                    code_now = FC_SKIP;
    else if (HALT && ptr_next != NUM_IDX) code_now = FC_EARLY_HALT;
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    idx_d   = idx_q;
    got_d   = got_q;
    exp_d   = exp_q;
    ptr_d   = ptr_q;
    cycle_d = cycle_q;
    case (state_q)
      MON_IDLE: begin
        if (START) state_d = MON_RUN;
      end
      MON_RUN: begin
        cycle_d = cycle_q + 32'd1;
        ptr_d   = ptr_next;
        if (code_now != FC_NONE) begin
          state_d = MON_FAIL;
          code_d  = code_now;
          idx_d   = ptr_q;
          got_d   = OUTPUT_PORT;
          exp_d   = cp_ans;
        end else if (HALT) begin
          state_d = MON_PASS;
        end else if (cycle_q == CYC_LAST) begin
          state_d = MON_TIMEOUT;
        end
      end
      default: ;
    endcase
    done_d = (state_d == MON_PASS) || (state_d == MON_FAIL) || (state_d == MON_TIMEOUT);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= MON_IDLE;
      done_q  <= 1'b0;
      code_q  <= FC_NONE;
      idx_q   <= '0;
      got_q   <= '0;
      exp_q   <= '0;
      ptr_q   <= '0;
      cycle_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      code_q  <= code_d;
      idx_q   <= idx_d;
      got_q   <= got_d;
      exp_q   <= exp_d;
      ptr_q   <= ptr_d;
      cycle_q <= cycle_d;
    end
  end

  assign STATE     = state_q;
  assign DONE      = done_q;
  assign FAIL_CODE = code_q;
  assign FAIL_IDX  = idx_q;
  assign FAIL_GOT  = got_q;
  assign FAIL_EXP  = exp_q;
  assign PASS_CNT  = ptr_q;
  assign CYCLE     = cycle_q;

endmodule
